// File: rtl/program_counter_rs.sv
// Fetch-stage program counter with increment, absolute load, relative branch and a return-address stack.
// Latency: controls sampled on a rising edge take effect in CounterValue right after that edge.
// Backpressure: Stall freezes PC, stack and flags for the cycle; Reset overrides Stall.
//
// Ports:
//   Clock, Reset (sync, active-high), Stall
//   LoadValue/LoadEnable  : absolute jump target (also the Call target)
//   Offset/OffsetEnable   : signed relative branch
//   Call/Return           : push PC+1 and jump / pop into PC
//   CounterValue          : registered instruction address
//   StackDepth/Full/Empty : stack occupancy (Full/Empty decoded from depth)
//   StackOverflow/Underflow : sticky error flags, cleared only by Reset
module program_counter_rs #(
  parameter int ADDR_WIDTH   = 16,
  parameter int OFFSET_WIDTH = 9,
  parameter int STACK_DEPTH  = 8,
  parameter logic [ADDR_WIDTH-1:0] RESET_VALUE = '0,
  localparam int DEPTH_W = $clog2(STACK_DEPTH + 1)
) (
  input  logic                    Clock,
  input  logic                    Reset,
  input  logic                    Stall,
  input  logic [ADDR_WIDTH-1:0]   LoadValue,
  input  logic                    LoadEnable,
  input  logic [OFFSET_WIDTH-1:0] Offset,
  input  logic                    OffsetEnable,
  input  logic                    Call,
  input  logic                    Return,
  output logic [ADDR_WIDTH-1:0]   CounterValue,
  output logic [DEPTH_W-1:0]      StackDepth,
  output logic                    StackFull,
  output logic                    StackEmpty,
  output logic                    StackOverflow,
  output logic                    StackUnderflow
);

  localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  logic [ADDR_WIDTH-1:0] stack_mem [STACK_DEPTH];

  logic [ADDR_WIDTH-1:0]   pc_nxt;
  logic [DEPTH_W-1:0]      depth_nxt;
  logic                    ovf_nxt;
  logic                    unf_nxt;
  logic                    push_en;
  logic [ADDR_WIDTH-1:0]   pc_inc;
  logic [ADDR_WIDTH-1:0]   offset_ext;
  logic signed [OFFSET_WIDTH-1:0] offset_s;
  logic [IDX_W-1:0]        top_idx;
  logic [IDX_W-1:0]        push_idx;

  assign StackFull  = (StackDepth == DEPTH_W'(STACK_DEPTH));
  assign StackEmpty = (StackDepth == '0);

  assign pc_inc   = CounterValue + ADDR_WIDTH'(1);
  // Widening a signed value replicates its sign bit.
  assign offset_s   = Offset;
  assign offset_ext = ADDR_WIDTH'(offset_s);

  // Top of stack is entry[depth-1]; the next free slot is entry[depth].
  assign top_idx  = IDX_W'(StackDepth - DEPTH_W'(1));
  assign push_idx = IDX_W'(StackDepth);

  always_comb begin
    pc_nxt    = CounterValue;
    depth_nxt = StackDepth;
    ovf_nxt   = StackOverflow;
    unf_nxt   = StackUnderflow;
    push_en   = 1'b0;

    if (Reset) begin
      pc_nxt    = RESET_VALUE;
      depth_nxt = '0;
      ovf_nxt   = 1'b0;
      unf_nxt   = 1'b0;
    end else if (Stall) begin
      // hold everything
    end else if (Return) begin
      // Return beats a simultaneous Call, so no push happens in that case.
      if (!StackEmpty) begin
        pc_nxt    = stack_mem[top_idx];
        depth_nxt = StackDepth - DEPTH_W'(1);
      end else begin
        pc_nxt  = pc_inc;
        unf_nxt = 1'b1;
      end
    end else if (Call) begin
      // The jump is always taken; only the push is dropped when full.
      pc_nxt = LoadValue;
      if (!StackFull) begin
        push_en   = 1'b1;
        depth_nxt = StackDepth + DEPTH_W'(1);
      end else begin
        ovf_nxt = 1'b1;
      end
    end else if (LoadEnable) begin
      pc_nxt = LoadValue;
    end else if (OffsetEnable) begin
      pc_nxt = CounterValue + offset_ext;
    end else begin
      pc_nxt = pc_inc;
    end
  end

  always_ff @(posedge Clock) begin
    CounterValue   <= pc_nxt;
    StackDepth     <= depth_nxt;
    StackOverflow  <= ovf_nxt;
    StackUnderflow <= unf_nxt;
  end

  // Stack storage carries no reset; depth alone decides which entries are valid.
  always_ff @(posedge Clock) begin
    if (push_en) begin
      stack_mem[push_idx] <= pc_inc;
    end
  end

endmodule

// File: tb/tb_program_counter_rs.sv
module tb_program_counter_rs;

  logic        Clock;
  logic        Reset;
  logic        Stall;
  logic [15:0] LoadValue;
  logic        LoadEnable;
  logic [8:0]  Offset;
  logic        OffsetEnable;
  logic        Call;
  logic        Return;
  logic [15:0] CounterValue;
  logic [3:0]  StackDepth;
  logic        StackFull;
  logic        StackEmpty;
  logic        StackOverflow;
  logic        StackUnderflow;

  program_counter_rs dut (
    .Clock(Clock), .Reset(Reset), .Stall(Stall),
    .LoadValue(LoadValue), .LoadEnable(LoadEnable),
    .Offset(Offset), .OffsetEnable(OffsetEnable),
    .Call(Call), .Return(Return),
    .CounterValue(CounterValue), .StackDepth(StackDepth),
    .StackFull(StackFull), .StackEmpty(StackEmpty),
    .StackOverflow(StackOverflow), .StackUnderflow(StackUnderflow)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  int tests_run = 0;
  int tests_failed = 0;

  typedef struct {
    bit          rst, stall, ret, call, ld, offen;
    logic [15:0] lv;
    logic [8:0]  off;
    logic [15:0] exp_pc;
    int          exp_depth;
    bit          exp_ovf, exp_unf;
  } vec_t;

  vec_t tbl[$];

  // Reference model state
  logic [15:0] m_pc;
  logic [15:0] m_stk[$];
  bit          m_ovf, m_unf;

  function automatic vec_t mk(bit rst, bit stall, bit ret, bit call, bit ld, bit offen,
                              logic [15:0] lv, logic [8:0] off,
                              logic [15:0] epc, int ed, bit eovf, bit eunf);
    vec_t v;
    v.rst = rst; v.stall = stall; v.ret = ret; v.call = call; v.ld = ld; v.offen = offen;
    v.lv = lv; v.off = off; v.exp_pc = epc; v.exp_depth = ed; v.exp_ovf = eovf; v.exp_unf = eunf;
    return v;
  endfunction

  // Drive one cycle of controls, let the edge happen, sample 1 time unit later.
  task automatic step(input bit rst, input bit stall, input bit ret, input bit call,
                      input bit ld, input bit offen, input logic [15:0] lv, input logic [8:0] off);
    Reset = rst; Stall = stall; Return = ret; Call = call;
    LoadEnable = ld; OffsetEnable = offen; LoadValue = lv; Offset = off;
    @(posedge Clock);
    #1;
  endtask

  task automatic check(input string nm, input logic [15:0] epc, input int ed,
                       input bit eovf, input bit eunf);
    bit efull, eempty;
    efull  = (ed == 8);
    eempty = (ed == 0);
    tests_run++;
    if (CounterValue !== epc || int'(StackDepth) != ed || StackFull !== efull ||
        StackEmpty !== eempty || StackOverflow !== eovf || StackUnderflow !== eunf) begin
      tests_failed++;
      $display("FAIL %s: got pc=%h depth=%0d full=%b empty=%b ovf=%b unf=%b; expected pc=%h depth=%0d full=%b empty=%b ovf=%b unf=%b",
               nm, CounterValue, StackDepth, StackFull, StackEmpty, StackOverflow, StackUnderflow,
               epc, ed, efull, eempty, eovf, eunf);
    end
  endtask

  // Behavioural model: spec rules with a queue as the LIFO.
  function automatic void model_step(bit rst, bit stall, bit ret, bit call, bit ld, bit offen,
                                     logic [15:0] lv, logic [8:0] off);
    int sext;
    if (rst) begin
      m_pc = 16'h0000; m_stk.delete(); m_ovf = 0; m_unf = 0;
    end else if (stall) begin
    end else if (ret) begin
      if (m_stk.size() > 0) m_pc = m_stk.pop_back();
      else begin m_pc = m_pc + 16'd1; m_unf = 1; end
    end else if (call) begin
      if (m_stk.size() < 8) m_stk.push_back(m_pc + 16'd1);
      else m_ovf = 1;
      m_pc = lv;
    end else if (ld) begin
      m_pc = lv;
    end else if (offen) begin
      sext = off[8] ? int'(off) - 512 : int'(off);
      m_pc = 16'((int'(m_pc) + sext + 65536) % 65536);
    end else begin
      m_pc = m_pc + 16'd1;
    end
  endfunction

  initial begin
    logic [15:0] pushed[$];
    logic [15:0] pc_before;
    step(1, 0, 0, 0, 0, 0, 16'h0, 9'h0);

    // Reset then 20 idle cycles.
    check("reset", 16'h0000, 0, 0, 0);
    for (int i = 1; i <= 20; i++) step(0, 0, 0, 0, 0, 0, 16'h0, 9'h0);
    check("idle20", 16'd20, 0, 0, 0);

    //            rst st ret cl ld of  lv        off      exp_pc   d  ov un
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 16'hFFFE, 9'h000, 16'hFFFE, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 16'h0000, 9'h000, 16'hFFFF, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 16'h0000, 9'h000, 16'h0000, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 16'h0100, 9'h000, 16'h0100, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 16'h0000, 9'h037, 16'h0137, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 16'h0000, 9'h1F0, 16'h0127, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 16'h0010, 9'h000, 16'h0010, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 0, 0, 16'h0200, 9'h000, 16'h0200, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 16'h0000, 9'h000, 16'h0201, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 16'h0000, 9'h000, 16'h0202, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 16'h0000, 9'h000, 16'h0203, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 0, 0, 16'h0300, 9'h000, 16'h0300, 2, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0, 0, 0, 16'h0000, 9'h000, 16'h0204, 1, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0, 0, 0, 16'h0000, 9'h000, 16'h0011, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 16'h0050, 9'h000, 16'h0050, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0, 0, 0, 16'h0000, 9'h000, 16'h0051, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 1, 0, 0, 16'h0600, 9'h000, 16'h0600, 1, 0, 1));
    tbl.push_back(mk(0, 0, 1, 1, 0, 0, 16'h0700, 9'h000, 16'h0052, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 1, 1, 16'h0800, 9'h005, 16'h0800, 0, 0, 1));
    tbl.push_back(mk(0, 1, 0, 1, 0, 0, 16'h0900, 9'h000, 16'h0800, 0, 0, 1));
    tbl.push_back(mk(0, 1, 0, 1, 0, 0, 16'h0900, 9'h000, 16'h0800, 0, 0, 1));
    tbl.push_back(mk(0, 1, 0, 1, 0, 0, 16'h0900, 9'h000, 16'h0800, 0, 0, 1));
    tbl.push_back(mk(1, 1, 0, 1, 0, 0, 16'h0900, 9'h000, 16'h0000, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 16'h0000, 9'h000, 16'h0001, 0, 0, 0));

    foreach (tbl[i]) begin
      step(tbl[i].rst, tbl[i].stall, tbl[i].ret, tbl[i].call, tbl[i].ld, tbl[i].offen,
           tbl[i].lv, tbl[i].off);
      check($sformatf("vec%0d", i), tbl[i].exp_pc, tbl[i].exp_depth,
            tbl[i].exp_ovf, tbl[i].exp_unf);
    end

    // Overflow: fill the stack, overflow once, then unwind in reverse order.
    step(1, 0, 0, 0, 0, 0, 16'h0, 9'h0);
    pc_before = 16'h0000;
    for (int i = 0; i < 8; i++) begin
      pushed.push_back(pc_before + 16'd1);
      pc_before = 16'h1000 + 16'(i * 16);
      step(0, 0, 0, 1, 0, 0, pc_before, 9'h0);
      check($sformatf("fill%0d", i), pc_before, i + 1, 0, 0);
    end
    step(0, 0, 0, 1, 0, 0, 16'h0400, 9'h0);
    check("overflow", 16'h0400, 8, 1, 0);
    for (int i = 7; i >= 0; i--) begin
      step(0, 0, 1, 0, 0, 0, 16'h0, 9'h0);
      check($sformatf("unwind%0d", i), pushed[i], i, 1, 0);
    end

    // Randomised run against the reference model.
    step(1, 0, 0, 0, 0, 0, 16'h0, 9'h0);
    model_step(1, 0, 0, 0, 0, 0, 16'h0, 9'h0);
    check("rand_reset", m_pc, m_stk.size(), m_ovf, m_unf);
    for (int n = 0; n < 3000; n++) begin
      bit rst, stall, ret, call, ld, offen;
      logic [15:0] lv;
      logic [8:0] off;
      rst   = ($urandom_range(0, 99) == 0);
      stall = ($urandom_range(0, 7) == 0);
      ret   = ($urandom_range(0, 4) == 0);
      call  = ($urandom_range(0, 3) == 0);
      ld    = ($urandom_range(0, 7) == 0);
      offen = ($urandom_range(0, 3) == 0);
      lv    = 16'($urandom);
      off   = 9'($urandom);
      step(rst, stall, ret, call, ld, offen, lv, off);
      model_step(rst, stall, ret, call, ld, offen, lv, off);
      check($sformatf("rand%0d", n), m_pc, m_stk.size(), m_ovf, m_unf);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
